axi_slave_mem: RTL and testbench



---
 rtl/axi_slave_pkg.sv | 21 ++
 rtl/axi_slave_regfile.sv | 37 +++
 rtl/axi_slave_mem.sv | 204 ++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the single-beat AXI slave memory.
package axi_slave_pkg;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic RESP_OKAY = 1'b1;
    localparam logic RESP_ERR  = 1'b0;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // Full-width compare so any set upper address bit counts as out of range.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned        depth,
                                           input int unsigned        lsb);
        return (addr >> lsb) < ADDR_W'(depth);
    endfunction

endpackage

// File: rtl/axi_slave_regfile.sv
// DEPTH x 128-bit register file: async clear, one byte-enabled write port and one
// combinational read port that returns pre-write data when both hit the same word.
module axi_slave_regfile
    import axi_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_slave_mem.sv
// Single-beat AXI-style slave backed by a local register file.
// Define AXI_SLV_WSTRB_EN to add the write_strobe byte-enable input.
module axi_slave_mem
    import axi_slave_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_LSB = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] write_address,
    input  logic              WDVALID,
    output logic              WDREADY,
    input  logic [DATA_W-1:0] write_data,
`ifdef AXI_SLV_WSTRB_EN
    input  logic [STRB_W-1:0] write_strobe,
`endif
    output logic              BVALID,
    input  logic              BREADY,
    output logic              BRESP,
    input  logic              RAVALID,
    output logic              RAREADY,
    input  logic [ADDR_W-1:0] read_address,
    output logic              RDVALID,
    input  logic              RDREADY,
    output logic [DATA_W-1:0] read_data,
    output logic              RRESP
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    w_state_e          w_state_q, w_state_d;
    logic              aw_done_q, aw_done_d, wd_done_q, wd_done_d;
    logic              awready_q, awready_d, wdready_q, wdready_d;
    logic              bvalid_q, bvalid_d, bresp_q, bresp_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d, strb_in;

    r_state_e          r_state_q, r_state_d;
    logic              raready_q, raready_d, rdvalid_q, rdvalid_d, rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data, rf_rdata;
    logic [STRB_W-1:0] wr_strb;
    logic              aw_hs, wd_hs, ar_hs, rd_in_range;

`ifdef AXI_SLV_WSTRB_EN
    assign strb_in = write_strobe;
`else
    assign strb_in = '1;
`endif

    assign aw_hs = AWVALID & awready_q;
    assign wd_hs = WDVALID & wdready_q;
    assign ar_hs = RAVALID & raready_q;
    assign rd_in_range = addr_in_range(read_address, DEPTH, ADDR_LSB);

    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        wd_done_d = wd_done_q;
        awready_d = awready_q;
        wdready_d = wdready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_en     = 1'b0;
        wr_addr   = awaddr_q;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = write_address;
                end
                if (wd_hs) begin
                    wd_done_d = 1'b1;
                    wdata_d   = write_data;
                    wstrb_d   = strb_in;
                end
                // Ready is also raised here on the first edge out of reset.
                awready_d = !aw_done_d;
                wdready_d = !wd_done_d;
                if (aw_done_d && wd_done_d) begin
                    wr_addr   = awaddr_d;
                    wr_data   = wdata_d;
                    wr_strb   = wstrb_d;
                    wr_en     = addr_in_range(awaddr_d, DEPTH, ADDR_LSB);
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_en ? RESP_OKAY : RESP_ERR;
                    aw_done_d = 1'b0;
                    wd_done_d = 1'b0;
                    awready_d = 1'b0;
                    wdready_d = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wdready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raready_d = raready_q;
        rdvalid_d = rdvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                raready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d   = rd_in_range ? rf_rdata : '0;
                    rresp_d   = rd_in_range ? RESP_OKAY : RESP_ERR;
                    rdvalid_d = 1'b1;
                    raready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RDREADY) begin
                    rdvalid_d = 1'b0;
                    raready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            wd_done_q <= 1'b0;
            awready_q <= 1'b0;
            wdready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_ERR;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            r_state_q <= R_IDLE;
            raready_q <= 1'b0;
            rdvalid_q <= 1'b0;
            rresp_q   <= RESP_ERR;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            wd_done_q <= wd_done_d;
            awready_q <= awready_d;
            wdready_q <= wdready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            r_state_q <= r_state_d;
            raready_q <= raready_d;
            rdvalid_q <= rdvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    axi_slave_regfile #(
        .DEPTH(DEPTH)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we_i   (wr_en),
        .waddr_i(wr_addr[ADDR_LSB +: IDX_W]),
        .wdata_i(wr_data),
        .wstrb_i(wr_strb),
        .raddr_i(read_address[ADDR_LSB +: IDX_W]),
        .rdata_o(rf_rdata)
    );

    assign AWREADY   = awready_q;
    assign WDREADY   = wdready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign RAREADY   = raready_q;
    assign RDVALID   = rdvalid_q;
    assign RRESP     = rresp_q;
    assign read_data = rdata_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the slave.
module tb_axi_slave_mem;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         AWVALID = 1'b0, WDVALID = 1'b0, RAVALID = 1'b0;
    logic         BREADY = 1'b0, RDREADY = 1'b0;
    logic [63:0]  write_address = '0, read_address = '0;
    logic [127:0] write_data = '0;
    logic         AWREADY, WDREADY, BVALID, BRESP, RAREADY, RDVALID, RRESP;
    logic [127:0] read_data;

    int checks = 0;
    int failures = 0;

    axi_slave_mem #(
        .DEPTH   (DEPTH),
        .ADDR_LSB(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .write_address(write_address),
        .WDVALID      (WDVALID),
        .WDREADY      (WDREADY),
        .write_data   (write_data),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .BRESP        (BRESP),
        .RAVALID      (RAVALID),
        .RAREADY      (RAREADY),
        .read_address (read_address),
        .RDVALID      (RDVALID),
        .RDREADY      (RDREADY),
        .read_data    (read_data),
        .RRESP        (RRESP)
    );

    always #5 clk = ~clk;

    // Transaction-level model: pending latched requests and outstanding responses.
    logic [127:0] m_mem [DEPTH];
    bit           m_started, m_aw_pend, m_w_pend, m_b_out, m_r_out, m_b_known, m_r_known;
    logic [63:0]  m_aw_addr;
    logic [127:0] m_w_data, m_rdata;
    logic         m_bresp, m_rresp;
    bit           last_aw_hs, last_w_hs, last_ar_hs;

    function automatic bit in_rng(input logic [63:0] a);
        return a < 64'(DEPTH * 16);
    endfunction

    function automatic int idx(input logic [63:0] a);
        return int'((a / 16) % DEPTH);
    endfunction

    function automatic bit e_awready();
        return m_started && !m_aw_pend && !m_b_out;
    endfunction

    function automatic bit e_wdready();
        return m_started && !m_w_pend && !m_b_out;
    endfunction

    function automatic bit e_raready();
        return m_started && !m_r_out;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_started = 0; m_aw_pend = 0; m_w_pend = 0; m_b_out = 0; m_r_out = 0;
        m_b_known = 1; m_r_known = 1; m_bresp = 0; m_rresp = 0; m_rdata = '0;
        last_aw_hs = 0; last_w_hs = 0; last_ar_hs = 0;
    endtask

    task automatic model_step();
        bit aw_hs, w_hs, ar_hs, b_hs;
        if (!reset) return;
        if (!m_started) begin
            m_started = 1;
            last_aw_hs = 0; last_w_hs = 0; last_ar_hs = 0;
            return;
        end
        aw_hs = AWVALID && e_awready();
        w_hs  = WDVALID && e_wdready();
        ar_hs = RAVALID && e_raready();
        b_hs  = m_b_out && BREADY;
        last_aw_hs = aw_hs; last_w_hs = w_hs; last_ar_hs = ar_hs;
        // Read is resolved before the write so a same-edge collision sees old data.
        if (ar_hs) begin
            m_r_out = 1; m_r_known = 1;
            m_rresp = in_rng(read_address);
            m_rdata = m_rresp ? m_mem[idx(read_address)] : '0;
        end else if (m_r_out && RDREADY) begin
            m_r_out = 0; m_r_known = 0;
        end
        if (aw_hs) begin m_aw_pend = 1; m_aw_addr = write_address; end
        if (w_hs) begin m_w_pend = 1; m_w_data = write_data; end
        if (m_aw_pend && m_w_pend) begin
            m_bresp = in_rng(m_aw_addr);
            if (m_bresp) m_mem[idx(m_aw_addr)] = m_w_data;
            m_b_out = 1; m_b_known = 1; m_aw_pend = 0; m_w_pend = 0;
        end else if (b_hs) begin
            m_b_out = 0; m_b_known = 0;
        end
    endtask

    task automatic check_all();
        chk("awready", AWREADY, e_awready());
        chk("wdready", WDREADY, e_wdready());
        chk("raready", RAREADY, e_raready());
        chk("bvalid", BVALID, m_b_out);
        chk("rdvalid", RDVALID, m_r_out);
        if (m_b_known) chk("bresp", BRESP, m_bresp);
        if (m_r_known) begin
            chk("rresp", RRESP, m_rresp);
            chk("read_data", read_data, m_rdata);
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge,
    // then the master drops any VALID that was just accepted.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (last_aw_hs) AWVALID = 0;
        if (last_w_hs) WDVALID = 0;
        if (last_ar_hs) RAVALID = 0;
    endtask

    task automatic drain();
        BREADY = 1; RDREADY = 1;
        for (int i = 0; i < 20 && (AWVALID || WDVALID || RAVALID || m_b_out || m_r_out); i++)
            tick();
        chk("drain_idle", {AWVALID, WDVALID, RAVALID, m_b_out, m_r_out}, 5'b0);
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = 64'($urandom_range(0, 19)) * 16 + 64'($urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) a[40] = 1'b1;
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        chk("rst_awready", AWREADY, 0);
        chk("rst_read_data", read_data, 0);
        @(negedge clk);
        reset = 1;
        check_all();
        tick();
        chk("rel_awready", AWREADY, 1);
        chk("rel_raready", RAREADY, 1);

        // AW and W together, then read back.
        AWVALID = 1; write_address = 64'h20; WDVALID = 1; write_data = 128'hDEAD_BEEF; BREADY = 1;
        tick();
        chk("t1_bvalid", BVALID, 1);
        chk("t1_bresp", BRESP, 1);
        tick();
        chk("t1_bclr", BVALID, 0);
        RAVALID = 1; read_address = 64'h20; RDREADY = 1;
        tick();
        chk("t1_rdvalid", RDVALID, 1);
        chk("t1_rdata", read_data, 128'hDEAD_BEEF);
        chk("t1_rresp", RRESP, 1);
        tick();

        // W leads AW by several cycles.
        WDVALID = 1; write_data = 128'h1111;
        tick();
        chk("t2_wdready", WDREADY, 0);
        tick(); tick();
        chk("t2_no_b", BVALID, 0);
        AWVALID = 1; write_address = 64'h10;
        tick();
        chk("t2_bvalid", BVALID, 1);
        chk("t2_model_mem1", m_mem[1], 128'h1111);
        tick();
        RAVALID = 1; read_address = 64'h1C;
        tick();
        chk("t2_rdata", read_data, 128'h1111);
        tick();

        // Out of range.
        AWVALID = 1; write_address = 64'h100; WDVALID = 1; write_data = 128'h77;
        tick();
        chk("t3_bresp", BRESP, 0);
        tick();
        RAVALID = 1; read_address = 64'h100;
        tick();
        chk("t3_rresp", RRESP, 0);
        chk("t3_rdata", read_data, 0);
        tick();

        // Stalled responses.
        BREADY = 0; RDREADY = 0;
        AWVALID = 1; write_address = 64'h40; WDVALID = 1; write_data = 128'hA5A5;
        RAVALID = 1; read_address = 64'h20;
        tick();
        repeat (5) tick();
        chk("t4_bvalid", BVALID, 1);
        chk("t4_awready", AWREADY, 0);
        chk("t4_rdvalid", RDVALID, 1);
        chk("t4_raready", RAREADY, 0);
        chk("t4_rdata", read_data, 128'hDEAD_BEEF);
        BREADY = 1; RDREADY = 1;
        tick();
        chk("t4_bclr", BVALID, 0);
        chk("t4_aw_back", AWREADY, 1);
        chk("t4_ra_back", RAREADY, 1);

        // Same-edge read and write of one word returns the old value.
        AWVALID = 1; write_address = 64'h30; WDVALID = 1; write_data = 128'h5;
        tick(); tick();
        AWVALID = 1; WDVALID = 1; write_data = 128'h9; RAVALID = 1; read_address = 64'h30;
        tick();
        chk("t5_old", read_data, 128'h5);
        tick();
        RAVALID = 1;
        tick();
        chk("t5_new", read_data, 128'h9);
        tick();

        // Reset while a write response is pending.
        BREADY = 0;
        AWVALID = 1; write_address = 64'h50; WDVALID = 1; write_data = 128'h3;
        tick();
        chk("t6_bvalid", BVALID, 1);
        reset = 0;
        #1;
        chk("t6_async_bvalid", BVALID, 0);
        chk("t6_async_awready", AWREADY, 0);
        model_reset();
        AWVALID = 0; WDVALID = 0; RAVALID = 0;
        @(negedge clk);
        check_all();
        reset = 1;
        tick();
        chk("t6_awready", AWREADY, 1);
        RAVALID = 1; read_address = 64'h20; RDREADY = 1;
        tick();
        chk("t6_cleared", read_data, 0);
        chk("t6_rresp", RRESP, 1);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!AWVALID && $urandom_range(0, 2) == 0) begin
                AWVALID = 1; write_address = rand_addr();
            end
            if (!WDVALID && $urandom_range(0, 2) == 0) begin
                WDVALID = 1; write_data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!RAVALID && $urandom_range(0, 2) == 0) begin
                RAVALID = 1; read_address = rand_addr();
            end
            BREADY = 1'($urandom_range(0, 1));
            RDREADY = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
